// File: rtl/updown_state_decoder_if.sv
// rtl/updown_state_decoder_if.sv - state bus in, decoded press events out
interface updown_state_decoder_if #(
  parameter int CNT_W = 8
);
  logic [2:0]       state_in;
  logic             clr;
  logic             step;
  logic             turn;
  logic             dir;
  logic [CNT_W-1:0] press_cnt;
  logic             err;

  modport master (
    output state_in, clr,
    input  step, turn, dir, press_cnt, err
  );

  modport slave (
    input  state_in, clr,
    output step, turn, dir, press_cnt, err
  );
endinterface

// File: rtl/updown_state_decoder.sv
// rtl/updown_state_decoder.sv - recovers press/turn events from the bouncing counter state bus
module updown_state_decoder #(
  parameter int CNT_W = 8
) (
  input logic                   clk,
  input logic                   rst,
  updown_state_decoder_if.slave bus
);
  typedef enum logic [1:0] {
    S_UP   = 2'd0,
    S_DOWN = 2'd1,
    S_SYNC = 2'd2,
    S_ERR  = 2'd3
  } mode_t;

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  mode_t            r_mode;
  logic [2:0]       r_prev;
  logic             r_dir;
  logic             r_step;
  logic             r_turn;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  mode_t            w_mode_nxt;
  logic             w_dir_nxt;
  logic             w_step_nxt;
  logic             w_turn_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_err_nxt;

  logic w_event;
  logic w_inc;
  logic w_dec;
  logic w_top_turn;
  logic w_bot_turn;
  logic w_end_pos;

  // +1/-1 are only legal away from the 7/0 ends; 7->0 and 0->7 never match
  assign w_event    = (bus.state_in != r_prev);
  assign w_inc      = (r_prev != 3'd7) && (bus.state_in == r_prev + 3'd1);
  assign w_dec      = (r_prev != 3'd0) && (bus.state_in == r_prev - 3'd1);
  assign w_top_turn = (r_prev == 3'd7) && (bus.state_in == 3'd6);
  assign w_bot_turn = (r_prev == 3'd0) && (bus.state_in == 3'd1);
  assign w_end_pos  = (bus.state_in == 3'd0) || (bus.state_in == 3'd7);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_mode <= S_UP;
      r_prev <= 3'd0;
      r_dir  <= 1'b1;
      r_step <= 1'b0;
      r_turn <= 1'b0;
      r_cnt  <= '0;
      r_err  <= 1'b0;
    end else begin
      r_mode <= w_mode_nxt;
      r_prev <= bus.state_in;
      r_dir  <= w_dir_nxt;
      r_step <= w_step_nxt;
      r_turn <= w_turn_nxt;
      r_cnt  <= w_cnt_nxt;
      r_err  <= w_err_nxt;
    end
  end

  always_comb begin
    w_mode_nxt = r_mode;
    w_dir_nxt  = r_dir;
    w_step_nxt = 1'b0;
    w_turn_nxt = 1'b0;
    w_cnt_nxt  = r_cnt;
    w_err_nxt  = r_err;

    if (bus.clr) begin
      w_cnt_nxt  = '0;
      w_err_nxt  = 1'b0;
      w_mode_nxt = S_SYNC;
    end else begin
      case (r_mode)
        S_UP: begin
          if (w_event) begin
            if (w_inc) begin
              w_step_nxt = 1'b1;
              w_cnt_nxt  = r_cnt + CNT_ONE;
            end else if (w_top_turn) begin
              w_step_nxt = 1'b1;
              w_turn_nxt = 1'b1;
              w_cnt_nxt  = r_cnt + CNT_ONE;
              w_mode_nxt = S_DOWN;
              w_dir_nxt  = 1'b0;
            end else begin
              w_err_nxt  = 1'b1;
              w_mode_nxt = S_ERR;
            end
          end
        end
        S_DOWN: begin
          if (w_event) begin
            if (w_dec) begin
              w_step_nxt = 1'b1;
              w_cnt_nxt  = r_cnt + CNT_ONE;
            end else if (w_bot_turn) begin
              w_step_nxt = 1'b1;
              w_turn_nxt = 1'b1;
              w_cnt_nxt  = r_cnt + CNT_ONE;
              w_mode_nxt = S_UP;
              w_dir_nxt  = 1'b1;
            end else begin
              w_err_nxt  = 1'b1;
              w_mode_nxt = S_ERR;
            end
          end
        end
        S_SYNC: begin
          // An end position fixes the direction without a press; otherwise wait for a clean step
          if (w_end_pos) begin
            w_mode_nxt = S_UP;
            w_dir_nxt  = 1'b1;
          end else if (w_event && w_inc) begin
            w_step_nxt = 1'b1;
            w_cnt_nxt  = r_cnt + CNT_ONE;
            w_mode_nxt = S_UP;
            w_dir_nxt  = 1'b1;
          end else if (w_event && w_dec) begin
            w_step_nxt = 1'b1;
            w_cnt_nxt  = r_cnt + CNT_ONE;
            w_mode_nxt = S_DOWN;
            w_dir_nxt  = 1'b0;
          end
        end
        default: begin
          w_err_nxt = 1'b1;
        end
      endcase
    end
  end

  assign bus.step      = r_step;
  assign bus.turn      = r_turn;
  assign bus.dir       = r_dir;
  assign bus.press_cnt = r_cnt;
  assign bus.err       = r_err;
endmodule
